// File: rtl/scaler_rupt_sched.sv
// scaler_rupt_sched: three timer counters (T3, T4, T5) advanced by the scaler
// 10 ms strobe. Counter overflows raise pending flags, and a fixed-priority
// arbiter hands the pending sources one at a time to the interrupt logic.
module scaler_rupt_sched #(
  parameter int WIDTH = 15
) (
  input  logic             CLOCK,
  input  logic             rst,
  input  logic             TICK,
  input  logic             WR,
  input  logic [1:0]       WSEL,
  input  logic [WIDTH-1:0] WDATA,
  input  logic [1:0]       RSEL,
  output logic [WIDTH-1:0] RDATA,
  input  logic             INHINT,
  input  logic             RUPT_ACK,
  output logic             RUPT_REQ,
  output logic [1:0]       RUPT_ID,
  output logic [2:0]       PEND,
  output logic [2:0]       OVRN,
  input  logic             CLR_OVRN
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  // Index 0 = T3, 1 = T4, 2 = T5 throughout.
  logic [WIDTH-1:0] cnt [3];
  logic [2:0]       wr_hit;
  logic [2:0]       ovf_evt;
  logic [2:0]       grant;
  logic [2:0]       ovrn_set;
  logic [1:0]       grant_id;
  logic             grant_valid;
  logic [0:0]       state;

  // Decode the write target and detect wrap events; a write on a tick edge
  // replaces the increment, so that counter cannot overflow on that edge.
  always_comb begin
    wr_hit  = '0;
    ovf_evt = '0;
    for (int i = 0; i < 3; i++) begin
      wr_hit[i]  = WR && (WSEL == 2'(i));
      ovf_evt[i] = TICK && !wr_hit[i] && (cnt[i] == '1);
    end
  end

  // Pick the pending source to grant: T5 first, then T3, then T4.
  always_comb begin
    grant       = '0;
    grant_id    = 2'd0;
    grant_valid = 1'b0;
    if (state == IDLE && !INHINT) begin
      if (PEND[2]) begin
        grant       = 3'b100;
        grant_id    = 2'd2;
        grant_valid = 1'b1;
      end else if (PEND[0]) begin
        grant       = 3'b001;
        grant_id    = 2'd0;
        grant_valid = 1'b1;
      end else if (PEND[1]) begin
        grant       = 3'b010;
        grant_id    = 2'd1;
        grant_valid = 1'b1;
      end
    end
  end

  // An overrun is an event on a source already pending, unless that pending
  // bit is being consumed by a grant on the very same edge.
  assign ovrn_set = ovf_evt & PEND & ~grant;

  // Load or advance the three timer counters.
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (wr_hit[i])
          cnt[i] <= WDATA;
        else if (TICK)
          cnt[i] <= cnt[i] + WIDTH'(1);
      end
    end
  end

  // Track pending and sticky overrun flags; a new overrun beats the clear.
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      PEND <= '0;
      OVRN <= '0;
    end else begin
      PEND <= (PEND & ~grant) | ovf_evt;
      OVRN <= ovrn_set | (CLR_OVRN ? 3'b000 : OVRN);
    end
  end

  // Request handshake: hold the request stable until acknowledged, then
  // spend at least one cycle idle before the next grant.
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      RUPT_REQ <= 1'b0;
      RUPT_ID  <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            state    <= REQ;
            RUPT_REQ <= 1'b1;
            RUPT_ID  <= grant_id;
          end
        end
        REQ: begin
          if (RUPT_ACK) begin
            state    <= IDLE;
            RUPT_REQ <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          RUPT_REQ <= 1'b0;
        end
      endcase
    end
  end

  // Combinational readback of the selected counter; select 3 reads zero.
  always_comb begin
    RDATA = '0;
    case (RSEL)
      2'd0:    RDATA = cnt[0];
      2'd1:    RDATA = cnt[1];
      2'd2:    RDATA = cnt[2];
      default: RDATA = '0;
    endcase
  end

endmodule

// File: tb/tb_scaler_rupt_sched.sv
// tb_scaler_rupt_sched: directed walk through the overflow, priority,
// collision, overrun and reset scenarios, then a randomized run, all checked
// against a behavioural model of the timer/interrupt scheduler.
module tb_scaler_rupt_sched;

  logic        CLOCK = 1'b0;
  logic        rst = 1'b1;
  logic        TICK = 1'b0;
  logic        WR = 1'b0;
  logic [1:0]  WSEL = 2'd3;
  logic [14:0] WDATA = '0;
  logic [1:0]  RSEL = 2'd0;
  logic [14:0] RDATA;
  logic        INHINT = 1'b0;
  logic        RUPT_ACK = 1'b0;
  logic        RUPT_REQ;
  logic [1:0]  RUPT_ID;
  logic [2:0]  PEND;
  logic [2:0]  OVRN;
  logic        CLR_OVRN = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state: counters as plain integers, flags per source (0=T3,1=T4,2=T5).
  int m_cnt [3];
  bit m_pend [3];
  bit m_ovrn [3];
  bit m_req;
  int m_id;
  bit last_tick;

  scaler_rupt_sched #(.WIDTH(15)) dut (
    .CLOCK(CLOCK), .rst(rst), .TICK(TICK), .WR(WR), .WSEL(WSEL),
    .WDATA(WDATA), .RSEL(RSEL), .RDATA(RDATA), .INHINT(INHINT),
    .RUPT_ACK(RUPT_ACK), .RUPT_REQ(RUPT_REQ), .RUPT_ID(RUPT_ID),
    .PEND(PEND), .OVRN(OVRN), .CLR_OVRN(CLR_OVRN)
  );

  always #10 CLOCK = ~CLOCK;

  task automatic checkValue(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i]  = 0;
      m_pend[i] = 0;
      m_ovrn[i] = 0;
    end
    m_req = 0;
    m_id  = 0;
  endtask

  function automatic logic [2:0] packFlags(input bit f0, input bit f1, input bit f2);
    return {f2, f1, f0};
  endfunction

  // Compare every visible output against the model, sweeping all read selects.
  task automatic checkOutput(input string tag);
    checkValue({tag, "_req"},  32'(RUPT_REQ), 32'(m_req));
    checkValue({tag, "_id"},   32'(RUPT_ID),  32'(m_id));
    checkValue({tag, "_pend"}, 32'(PEND), 32'(packFlags(m_pend[0], m_pend[1], m_pend[2])));
    checkValue({tag, "_ovrn"}, 32'(OVRN), 32'(packFlags(m_ovrn[0], m_ovrn[1], m_ovrn[2])));
    for (int s = 0; s < 4; s++) begin
      RSEL = 2'(s);
      #1;
      checkValue({tag, "_rdata"}, 32'(RDATA), (s == 3) ? 32'd0 : 32'(m_cnt[s]));
    end
  endtask

  task automatic readCounter(input int sel, output int value);
    RSEL = 2'(sel);
    #1;
    value = int'(RDATA);
  endtask

  // Drive one cycle of inputs (called at a falling edge), advance the model
  // by the scheduler rules, then check just after the rising edge.
  task automatic applyStimulus(input bit tick, input bit wr, input int wsel,
                               input int wdata, input bit inhint, input bit ack,
                               input bit clr, input string tag);
    int  n_cnt [3];
    bit  n_pend [3];
    bit  n_ovrn [3];
    bit  evt [3];
    bit  hit [3];
    int  order [3];
    int  gnt;
    order[0] = 2; order[1] = 0; order[2] = 1;
    TICK = tick; WR = wr; WSEL = 2'(wsel); WDATA = 15'(wdata);
    INHINT = inhint; RUPT_ACK = ack; CLR_OVRN = clr;
    gnt = -1;
    if (!m_req && !inhint) begin
      for (int k = 0; k < 3; k++)
        if (gnt < 0 && m_pend[order[k]]) gnt = order[k];
    end
    for (int i = 0; i < 3; i++) begin
      hit[i] = wr && (wsel == i);
      evt[i] = tick && !hit[i] && (m_cnt[i] == 32767);
      n_cnt[i] = hit[i] ? (wdata % 32768) : (tick ? (m_cnt[i] + 1) % 32768 : m_cnt[i]);
      if (evt[i] && m_pend[i] && gnt != i) n_ovrn[i] = 1;
      else if (clr) n_ovrn[i] = 0;
      else n_ovrn[i] = m_ovrn[i];
      n_pend[i] = evt[i] ? 1'b1 : ((gnt == i) ? 1'b0 : m_pend[i]);
    end
    @(posedge CLOCK);
    #2;
    TICK = 0; WR = 0; RUPT_ACK = 0; CLR_OVRN = 0;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = n_cnt[i]; m_pend[i] = n_pend[i]; m_ovrn[i] = n_ovrn[i];
    end
    if (m_req && ack) m_req = 0;
    else if (gnt >= 0) begin
      m_req = 1;
      m_id  = gnt;
    end
    last_tick = tick;
    checkOutput(tag);
    @(negedge CLOCK);
  endtask

  initial begin
    int v;
    int t3_before;
    int t5_before;
    bit tk;
    bit wr;
    bit ack;
    int wd;
    modelReset();
    last_tick = 0;

    // Reset state
    repeat (2) @(negedge CLOCK);
    checkOutput("reset");
    #3 rst = 0;
    @(negedge CLOCK);

    // Overflow and handshake
    applyStimulus(0, 1, 0, 'h7FFE, 0, 0, 0, "ovf_wr");
    applyStimulus(1, 0, 3, 0, 0, 0, 0, "ovf_tick1");
    applyStimulus(0, 0, 3, 0, 0, 0, 0, "ovf_gap");
    applyStimulus(1, 0, 3, 0, 0, 0, 0, "ovf_tick2");
    readCounter(0, v);
    checkValue("plan_t3_wrapped", 32'(v), 32'd0);
    checkValue("plan_pend_t3", 32'(PEND), 32'b001);
    applyStimulus(0, 0, 3, 0, 0, 0, 0, "ovf_grant");
    checkValue("plan_req_up", 32'(RUPT_REQ), 32'd1);
    checkValue("plan_req_id0", 32'(RUPT_ID), 32'd0);
    checkValue("plan_pend_clr", 32'(PEND), 32'd0);
    applyStimulus(0, 0, 3, 0, 0, 1, 0, "ovf_ack");
    checkValue("plan_req_down", 32'(RUPT_REQ), 32'd0);

    // Priority: all three overflow together
    applyStimulus(0, 1, 0, 'h7FFF, 0, 0, 0, "pri_wr0");
    applyStimulus(0, 1, 1, 'h7FFF, 0, 0, 0, "pri_wr1");
    applyStimulus(0, 1, 2, 'h7FFF, 0, 0, 0, "pri_wr2");
    applyStimulus(1, 0, 3, 0, 0, 0, 0, "pri_tick");
    checkValue("plan_pend_all", 32'(PEND), 32'b111);
    applyStimulus(0, 0, 3, 0, 0, 0, 0, "pri_g1");
    checkValue("plan_first_id2", 32'(RUPT_ID), 32'd2);
    applyStimulus(0, 0, 3, 0, 0, 0, 0, "pri_hold1");
    applyStimulus(0, 0, 3, 0, 0, 1, 0, "pri_ack1");
    checkValue("plan_idle_gap1", 32'(RUPT_REQ), 32'd0);
    applyStimulus(0, 0, 3, 0, 0, 0, 0, "pri_g2");
    checkValue("plan_second_id0", 32'(RUPT_ID), 32'd0);
    applyStimulus(0, 0, 3, 0, 0, 1, 0, "pri_ack2");
    applyStimulus(0, 0, 3, 0, 0, 0, 0, "pri_g3");
    checkValue("plan_third_id1", 32'(RUPT_ID), 32'd1);
    applyStimulus(0, 0, 3, 0, 0, 1, 0, "pri_ack3");
    applyStimulus(0, 0, 3, 0, 0, 0, 0, "pri_quiet");

    // Write/tick collision on T4
    applyStimulus(0, 1, 1, 'h7FFF, 0, 0, 0, "col_wr");
    readCounter(0, t3_before);
    readCounter(2, t5_before);
    applyStimulus(1, 1, 1, 'h0123, 0, 0, 0, "col_tick");
    readCounter(1, v);
    checkValue("plan_col_t4", 32'(v), 32'h0123);
    checkValue("plan_col_pend1", 32'(PEND[1]), 32'd0);
    readCounter(0, v);
    checkValue("plan_col_t3", 32'(v), 32'((t3_before + 1) % 32768));
    readCounter(2, v);
    checkValue("plan_col_t5", 32'(v), 32'((t5_before + 1) % 32768));

    // Overrun under inhibit, clear, then release
    applyStimulus(0, 1, 2, 'h7FFF, 1, 0, 0, "ovr_wr1");
    applyStimulus(1, 0, 3, 0, 1, 0, 0, "ovr_tick1");
    applyStimulus(0, 1, 2, 'h7FFF, 1, 0, 0, "ovr_wr2");
    applyStimulus(1, 0, 3, 0, 1, 0, 0, "ovr_tick2");
    checkValue("plan_ovr_pend2", 32'(PEND[2]), 32'd1);
    checkValue("plan_ovr_flag2", 32'(OVRN[2]), 32'd1);
    checkValue("plan_ovr_noreq", 32'(RUPT_REQ), 32'd0);
    applyStimulus(0, 0, 3, 0, 1, 0, 1, "ovr_clr");
    checkValue("plan_ovr_cleared", 32'(OVRN), 32'd0);
    applyStimulus(0, 0, 3, 0, 0, 0, 0, "ovr_release");
    checkValue("plan_rel_req", 32'(RUPT_REQ), 32'd1);
    checkValue("plan_rel_id2", 32'(RUPT_ID), 32'd2);

    // Asynchronous reset in the middle of a request
    #3 rst = 1;
    #1;
    modelReset();
    checkOutput("async_rst");
    #4 rst = 0;
    @(negedge CLOCK);
    applyStimulus(0, 0, 3, 0, 0, 1, 0, "post_rst_ack");

    // Randomized run
    for (int n = 0; n < 600; n++) begin
      tk  = !last_tick && ($urandom_range(0, 1) == 1);
      wr  = ($urandom_range(0, 3) == 0);
      wd  = ($urandom_range(0, 1) == 1) ? (32767 - int'($urandom_range(0, 2)))
                                        : int'($urandom_range(0, 32767));
      ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      applyStimulus(tk, wr, int'($urandom_range(0, 3)), wd,
                    ($urandom_range(0, 5) == 0), ack,
                    ($urandom_range(0, 9) == 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
